// File: rtl/icache_nwa_wide_comp_if.sv
// Bus bundle for the compressed-instruction cache: processor fetch port,
// line-fill memory port and the event counters.
// The slave modport is the cache's view; master is the surrounding system.
interface icache_nwa_wide_comp_if #(
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_BLOCKS = 4
);

  logic                                proc_valid;
  logic                                proc_ready;
  logic [31:0]                         proc_addr;
  logic [8*BLOCK_SIZE-1:0]             proc_rdata;
  logic                                flush;

  logic                                mem_req_valid;
  logic                                mem_req_ready;
  logic [31:0]                         mem_req_addr;
  logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]  mem_req_rdata;

  logic [31:0]                         hit_count;
  logic [31:0]                         miss_count;

  modport slave (
    input  proc_valid, proc_addr, flush, mem_req_ready, mem_req_rdata,
    output proc_ready, proc_rdata, mem_req_valid, mem_req_addr,
           hit_count, miss_count
  );

  modport master (
    output proc_valid, proc_addr, flush, mem_req_ready, mem_req_rdata,
    input  proc_ready, proc_rdata, mem_req_valid, mem_req_addr,
           hit_count, miss_count
  );

endinterface

// File: rtl/icache_nwa_wide_comp.sv
// N-way set-associative instruction cache for compressed (narrow) fetches.
// Each block sits in its own 4-byte address slot; a miss fetches the whole
// line from memory in one beat and forwards the requested block directly.
// Victims are the lowest invalid way, else a per-set round-robin pointer.
// Flush clears valid bits immediately, or right after an in-flight fill.
module icache_nwa_wide_comp #(
  parameter int CACHE_SIZE = 512,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  icache_nwa_wide_comp_if.slave   bus
);

  localparam int NUM_SETS = CACHE_SIZE / (NUM_WAYS * NUM_BLOCKS * BLOCK_SIZE);
  localparam int BLK_W    = $clog2(NUM_BLOCKS);
  localparam int IDX_W    = $clog2(NUM_SETS);
  localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BW       = 8 * BLOCK_SIZE;
  localparam int LINE_LSB = BLK_W + 2;
  localparam int TAG_LSB  = LINE_LSB + IDX_W;
  localparam int TAG_W    = 32 - TAG_LSB;

  typedef logic [NUM_BLOCKS-1:0][BW-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Cache storage; valid bits and victim pointers are the only reset state
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [WAY_W-1:0]    rr_q     [NUM_SETS];
  logic [TAG_W-1:0]    tag_mem  [NUM_WAYS][NUM_SETS];
  line_t               data_mem [NUM_WAYS][NUM_SETS];

  logic                flush_pend_q;
  logic [31:2]         miss_addr_q;

  logic                proc_ready_q;
  logic [BW-1:0]       proc_rdata_q;
  logic                mem_req_valid_q;
  logic [31:0]         mem_req_addr_q;
  logic [31:0]         hit_cnt_q;
  logic [31:0]         miss_cnt_q;

  // Lookup fields come straight from the processor address
  logic [IDX_W-1:0]    lk_idx;
  logic [TAG_W-1:0]    lk_tag;
  logic [BLK_W-1:0]    lk_blk;

  // Fill fields come from the address captured when the miss was taken
  logic [IDX_W-1:0]    ms_idx;
  logic [TAG_W-1:0]    ms_tag;
  logic [BLK_W-1:0]    ms_blk;

  logic                unused_addr_bits;

  line_t               fill_line;
  line_t               hit_line;
  logic                hit_any;
  logic [BW-1:0]       hit_block;
  logic [WAY_W-1:0]    victim_way;
  logic                victim_rr;
  logic [WAY_W-1:0]    rr_next;
  logic                flush_now;

  logic                do_hit;
  logic                do_miss;
  logic                do_fill;
  logic                do_fwd;

  assign lk_idx = bus.proc_addr[LINE_LSB +: IDX_W];
  assign lk_tag = bus.proc_addr[TAG_LSB +: TAG_W];
  assign lk_blk = bus.proc_addr[2 +: BLK_W];

  assign ms_idx = miss_addr_q[LINE_LSB +: IDX_W];
  assign ms_tag = miss_addr_q[TAG_LSB +: TAG_W];
  assign ms_blk = miss_addr_q[2 +: BLK_W];

  assign unused_addr_bits = ^bus.proc_addr[1:0];

  assign fill_line = bus.mem_req_rdata;

  // A flush (new or deferred from a fill) takes effect outside MISS only
  assign flush_now = (state_q != MISS) && (bus.flush || flush_pend_q);

  assign bus.proc_ready    = proc_ready_q;
  assign bus.proc_rdata    = proc_rdata_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.hit_count     = hit_cnt_q;
  assign bus.miss_count    = miss_cnt_q;

  // Tag compare across all ways of the addressed set
  always_comb begin
    hit_any  = 1'b0;
    hit_line = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[lk_idx][w] && (tag_mem[w][lk_idx] == lk_tag)) begin
        hit_any  = 1'b1;
        hit_line = data_mem[w][lk_idx];
      end
    end
    hit_block = hit_line[lk_blk];
  end

  // Victim choice for the pending fill: lowest invalid way beats round-robin
  always_comb begin
    victim_way = rr_q[ms_idx];
    victim_rr  = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[ms_idx][w]) begin
        victim_way = WAY_W'(w);
        victim_rr  = 1'b0;
      end
    end
    if (rr_q[ms_idx] == WAY_W'(NUM_WAYS - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = rr_q[ms_idx] + WAY_W'(1);
    end
  end

  // Next-state logic and the event strobes that drive all registered updates
  always_comb begin
    state_d = state_q;
    do_hit  = 1'b0;
    do_miss = 1'b0;
    do_fill = 1'b0;
    do_fwd  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.proc_valid) begin
          if (hit_any && !flush_now) begin
            do_hit  = 1'b1;
            state_d = DRAIN;
          end else begin
            do_miss = 1'b1;
            state_d = MISS;
          end
        end
      end
      MISS: begin
        if (bus.mem_req_ready) begin
          do_fill = 1'b1;
          if (bus.proc_valid) begin
            do_fwd  = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (!bus.proc_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Processor response, memory request and saturating counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      proc_ready_q    <= 1'b0;
      proc_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      miss_addr_q     <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      proc_ready_q <= do_hit || do_fwd;
      if (do_hit) begin
        proc_rdata_q <= hit_block;
      end else if (do_fwd) begin
        proc_rdata_q <= fill_line[ms_blk];
      end
      if (do_miss) begin
        mem_req_valid_q <= 1'b1;
        mem_req_addr_q  <= {bus.proc_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
        miss_addr_q     <= bus.proc_addr[31:2];
      end else if (do_fill) begin
        mem_req_valid_q <= 1'b0;
      end
      if (do_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (do_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  // Valid bits, victim pointers and the deferred flush request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_pend_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (flush_now) begin
        flush_pend_q <= 1'b0;
        for (int s = 0; s < NUM_SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end else begin
        if ((state_q == MISS) && bus.flush) begin
          flush_pend_q <= 1'b1;
        end
        if (do_fill) begin
          valid_q[ms_idx][victim_way] <= 1'b1;
          if (victim_rr) begin
            rr_q[ms_idx] <= rr_next;
          end
        end
      end
    end
  end

  // Tag and line storage; reset aborts a fill by leaving the FSM outside MISS
  always_ff @(posedge clk) begin
    if (do_fill) begin
      tag_mem[victim_way][ms_idx]  <= ms_tag;
      data_mem[victim_way][ms_idx] <= fill_line;
    end
  end

endmodule

// File: tb/tb_icache_nwa_wide_comp.sv
// Scoreboard bench for icache_nwa_wide_comp with default parameters
// (2 ways, 32 sets, 4 blocks of 2 bytes, index = addr[8:4]).
module tb_icache_nwa_wide_comp;

  localparam int NS = 32;
  localparam int NW = 2;

  logic clk    = 1'b0;
  logic resetn = 1'b1;

  always #5 clk = ~clk;

  icache_nwa_wide_comp_if #(.BLOCK_SIZE(2), .NUM_BLOCKS(4)) bus ();

  icache_nwa_wide_comp #(
    .CACHE_SIZE(512),
    .NUM_WAYS  (NW),
    .NUM_BLOCKS(4),
    .BLOCK_SIZE(2)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] exp_rdata_q [$];
  logic [31:0] exp_mem_q   [$];

  int mem_delay = 1;
  bit mem_hold  = 1'b0;

  // Reference model: which line address lives in each way of each set
  bit          m_valid [NS][NW];
  logic [31:0] m_line  [NS][NW];
  int          m_rr    [NS];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  function automatic logic [63:0] mem_line(input logic [31:0] la);
    if (la == 32'h10) return 64'h4444_3333_2222_1111;
    return {la ^ 32'h5A5A_C3C3, la * 32'h9E37_79B1};
  endfunction

  function automatic logic [15:0] exp_block(input logic [31:0] a);
    logic [63:0] l;
    int          b;
    l = mem_line({a[31:4], 4'h0});
    b = int'(a[3:2]);
    return 16'(l >> (16 * b));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s at %0t", name, $time);
  endtask

  task automatic modelFlush();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic modelReset();
    modelFlush();
    m_hits   = '0;
    m_misses = '0;
  endtask

  function automatic bit modelIsHit(input logic [31:0] a);
    int s;
    s = int'(a[8:4]);
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && (m_line[s][w] == {a[31:4], 4'h0})) return 1'b1;
    return 1'b0;
  endfunction

  // One fetch as seen by the specification: hit, or miss plus fill into a victim
  task automatic modelFetch(input logic [31:0] a, input bit flush_first, output bit hit);
    int s;
    int v;
    if (flush_first) modelFlush();
    s   = int'(a[8:4]);
    hit = modelIsHit(a);
    if (hit) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
    end else begin
      if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 1;
      v = -1;
      for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
      if (v < 0) begin
        v       = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % NW;
      end
      m_valid[s][v] = 1'b1;
      m_line[s][v]  = {a[31:4], 4'h0};
    end
  endtask

  task automatic checkCounters();
    checkOutput("hit_count", bus.hit_count, m_hits);
    checkOutput("miss_count", bus.miss_count, m_misses);
  endtask

  // Normal fetch held until served, optionally with flush in the lookup cycle
  task automatic applyStimulus(input logic [31:0] a, input bit with_flush);
    bit hit;
    int n;
    modelFetch(a, with_flush, hit);
    exp_rdata_q.push_back(exp_block(a));
    if (!hit) exp_mem_q.push_back({a[31:4], 4'h0});
    bus.proc_addr  = a;
    bus.proc_valid = 1'b1;
    bus.flush      = with_flush;
    @(negedge clk);
    bus.flush = 1'b0;
    n = 0;
    while ((bus.proc_ready !== 1'b1) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) reportFail("proc_ready timeout");
    bus.proc_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic applyFlush();
    bus.flush = 1'b1;
    modelFlush();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic waitMemValid(input logic level, input string name);
    int n;
    n = 0;
    while ((bus.mem_req_valid !== level) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) reportFail(name);
  endtask

  // Processor gives up mid-miss: the fill lands but no response is expected
  task automatic applyAbort(input logic [31:0] a);
    bit hit;
    modelFetch(a, 1'b0, hit);
    exp_mem_q.push_back({a[31:4], 4'h0});
    mem_delay      = 2;
    bus.proc_addr  = a;
    bus.proc_valid = 1'b1;
    @(negedge clk);
    waitMemValid(1'b1, "abort request timeout");
    bus.proc_valid = 1'b0;
    waitMemValid(1'b0, "abort fill timeout");
    @(negedge clk);
  endtask

  // Flush raised while the fill is outstanding: applied after the fill lands
  task automatic applyFlushDuringMiss(input logic [31:0] a);
    bit hit;
    int n;
    modelFetch(a, 1'b0, hit);
    exp_rdata_q.push_back(exp_block(a));
    exp_mem_q.push_back({a[31:4], 4'h0});
    mem_delay      = 3;
    bus.proc_addr  = a;
    bus.proc_valid = 1'b1;
    @(negedge clk);
    waitMemValid(1'b1, "flush-miss request timeout");
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n = 0;
    while ((bus.proc_ready !== 1'b1) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) reportFail("flush-miss ready timeout");
    modelFlush();
    bus.proc_valid = 1'b0;
    @(negedge clk);
  endtask

  // Reset in the middle of an outstanding fill must clear outputs at once
  task automatic applyResetDuringMiss(input logic [31:0] a);
    bit hit;
    mem_hold = 1'b1;
    modelFetch(a, 1'b0, hit);
    exp_mem_q.push_back({a[31:4], 4'h0});
    bus.proc_addr  = a;
    bus.proc_valid = 1'b1;
    @(negedge clk);
    waitMemValid(1'b1, "reset-miss request timeout");
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("rst mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("rst mem_req_addr", bus.mem_req_addr, 0);
    checkOutput("rst proc_ready", bus.proc_ready, 0);
    checkOutput("rst hit_count", bus.hit_count, 0);
    checkOutput("rst miss_count", bus.miss_count, 0);
    bus.proc_valid = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    resetn   = 1'b1;
    mem_hold = 1'b0;
    @(negedge clk);
  endtask

  // Memory responder: checks each request address and its stability
  initial begin
    bit          busy;
    int          wait_cnt;
    logic [31:0] saved;
    busy              = 1'b0;
    wait_cnt          = 0;
    saved             = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_req_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      if (!resetn || (bus.mem_req_valid !== 1'b1)) begin
        busy = 1'b0;
      end else begin
        if (!busy) begin
          busy     = 1'b1;
          saved    = bus.mem_req_addr;
          wait_cnt = mem_delay;
          if (exp_mem_q.size() == 0) reportFail("unexpected mem request");
          else checkOutput("mem_req_addr", bus.mem_req_addr, exp_mem_q.pop_front());
        end else begin
          checkOutput("mem_req_addr stable", bus.mem_req_addr, saved);
        end
        if (!mem_hold) begin
          if (wait_cnt == 0) begin
            bus.mem_req_ready = 1'b1;
            bus.mem_req_rdata = mem_line(saved);
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever proc_ready is seen
  initial begin
    bit          prev_ready;
    logic [15:0] last_exp;
    prev_ready = 1'b0;
    last_exp   = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        prev_ready = 1'b0;
        last_exp   = '0;
      end else begin
        if (bus.proc_ready === 1'b1) begin
          checkOutput("proc_ready single pulse", prev_ready, 0);
          if (exp_rdata_q.size() == 0) begin
            reportFail("unexpected proc_ready");
          end else begin
            last_exp = exp_rdata_q.pop_front();
            checkOutput("proc_rdata", bus.proc_rdata, last_exp);
          end
        end else begin
          checkOutput("proc_rdata hold", bus.proc_rdata, last_exp);
        end
        prev_ready = (bus.proc_ready === 1'b1);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [31:0] a;
    int          r;
    bus.proc_valid = 1'b0;
    bus.proc_addr  = '0;
    bus.flush      = 1'b0;
    modelReset();

    #1 resetn = 1'b0;
    #2;
    checkOutput("reset proc_ready", bus.proc_ready, 0);
    checkOutput("reset proc_rdata", bus.proc_rdata, 0);
    checkOutput("reset mem_req_valid", bus.mem_req_valid, 0);
    checkOutput("reset mem_req_addr", bus.mem_req_addr, 0);
    checkOutput("reset hit_count", bus.hit_count, 0);
    checkOutput("reset miss_count", bus.miss_count, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // cold miss, then hit in the same line
    mem_delay = 1;
    applyStimulus(32'h010, 1'b0);
    checkCounters();
    applyStimulus(32'h014, 1'b0);
    checkCounters();

    // two lines resident in set 1
    applyStimulus(32'h210, 1'b0);
    applyStimulus(32'h010, 1'b0);
    applyStimulus(32'h210, 1'b0);
    checkCounters();

    // round-robin eviction in a full set
    applyStimulus(32'h410, 1'b0);
    applyStimulus(32'h218, 1'b0);
    applyStimulus(32'h01C, 1'b0);
    applyStimulus(32'h414, 1'b0);
    checkCounters();

    // flush in idle, flush with lookup, flush during a fill
    applyFlush();
    applyStimulus(32'h010, 1'b0);
    applyStimulus(32'h014, 1'b1);
    applyFlushDuringMiss(32'h610);
    applyStimulus(32'h610, 1'b0);
    checkCounters();

    // processor abort and reset abort
    applyAbort(32'h810);
    applyStimulus(32'h814, 1'b0);
    checkCounters();
    applyFlush();
    applyResetDuringMiss(32'h010);
    applyStimulus(32'h010, 1'b0);
    checkCounters();

    // randomized traffic over a small address pool to force conflicts
    for (int i = 0; i < 250; i++) begin
      a = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 4) |
          ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      mem_delay = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 5) begin
        applyFlush();
        applyStimulus(a, 1'b0);
      end else if (r < 10) begin
        applyStimulus(a, 1'b1);
      end else if ((r < 16) && !modelIsHit(a)) begin
        applyAbort(a);
      end else if ((r < 20) && !modelIsHit(a)) begin
        applyFlushDuringMiss(a);
      end else begin
        applyStimulus(a, 1'b0);
      end
      if ((i % 25) == 24) checkCounters();
    end

    repeat (3) @(negedge clk);
    checkCounters();
    checkOutput("pending responses", exp_rdata_q.size(), 0);
    checkOutput("pending mem requests", exp_mem_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_nwa_wide_comp.md
ICACHE_NWA_WIDE_COMP -- requirements
Module: icache_nwa_wide_comp

Interface
REQ-001 SHALL have parameter CACHE_SIZE, default 512, meaning total data capacity in bytes.
REQ-002 SHALL have parameter NUM_WAYS, default 2, meaning associativity; power of two, 1..8.
REQ-003 SHALL have parameter NUM_BLOCKS, default 4, meaning blocks per line; power of two, at least 2.
REQ-004 SHALL have parameter BLOCK_SIZE, default 2, meaning bytes per block (compressed instruction width).
REQ-005 SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port resetn, input, 1 bit, meaning reset; asynchronous, active-low.
REQ-007 SHALL have port proc_valid, input, 1 bit, meaning processor fetch request, held until served.
REQ-008 SHALL have port proc_ready, output, 1 bit, meaning proc_rdata valid; one-cycle pulse.
REQ-009 SHALL have port proc_addr, input, 32 bits, meaning fetch address.
REQ-010 SHALL have port proc_rdata, output, 8*BLOCK_SIZE bits, meaning the fetched block.
REQ-011 SHALL have port flush, input, 1 bit, meaning invalidate all lines.
REQ-012 SHALL have port mem_req_valid, output, 1 bit, meaning line fill request.
REQ-013 SHALL have port mem_req_ready, input, 1 bit, meaning mem_req_rdata valid; completes the fill.
REQ-014 SHALL have port mem_req_addr, output, 32 bits, meaning line-aligned fill address.
REQ-015 SHALL have port mem_req_rdata, input, 8*BLOCK_SIZE*NUM_BLOCKS bits, meaning the full line; block 0 sits in the LSBs.
REQ-016 SHALL have ports hit_count and miss_count, output, 32 bits each, meaning saturating event counters.

Function
REQ-017 SHALL decode addresses as follows:
- NUM_SETS = CACHE_SIZE/(NUM_WAYS*NUM_BLOCKS*BLOCK_SIZE).
- Byte offset is the 2 bits [1:0], ignored; each block occupies one 4-byte address slot.
- Block offset is the next log2(NUM_BLOCKS) bits.
- Index is the next log2(NUM_SETS) bits.
- Tag is the remaining upper bits.
REQ-018 SHALL store per way and per set: valid bit, tag and full line; per set: a round-robin victim pointer of log2(NUM_WAYS) bits.
REQ-019 SHALL implement FSM states IDLE, MISS, DRAIN.
REQ-020 IDLE, when proc_valid=1 and a tag matches in a valid way (hit):
- next cycle proc_ready=1 and proc_rdata = the selected block from the hit way;
- hit_count increments;
- state goes to DRAIN.
REQ-021 IDLE, when proc_valid=1 and no way hits (miss):
- latch proc_addr;
- next cycle mem_req_valid=1 and mem_req_addr = {latched addr[31:OFFSET+2], zeros};
- miss_count increments;
- state goes to MISS.
REQ-022 MISS: mem_req_valid and mem_req_addr SHALL stay stable until mem_req_ready=1.
REQ-023 MISS, on the cycle mem_req_ready=1:
- write mem_req_rdata, tag and valid=1 into the victim way;
- mem_req_valid goes to 0 next cycle.
REQ-024 After the fill, if proc_valid is still 1:
- next cycle proc_ready=1 and proc_rdata = the block forwarded from mem_req_rdata;
- state goes to DRAIN.
REQ-025 After the fill, if proc_valid is 0: the fill still completes, no proc_ready is issued, and state goes to IDLE.
REQ-026 Victim selection:
- the lowest-numbered invalid way in the set;
- otherwise the way at the set's round-robin pointer, which then increments modulo NUM_WAYS;
- a hit SHALL NOT move the pointer.
REQ-027 DRAIN: proc_ready=0; return to IDLE on the first cycle proc_valid=0. No new lookup occurs while in DRAIN.
REQ-028 proc_ready SHALL never be high for two consecutive cycles; proc_rdata holds its value until the next proc_ready.
REQ-029 flush sampled high in IDLE or DRAIN SHALL clear all valid bits and victim pointers in that cycle. A lookup in the same cycle SHALL be treated as a miss.
REQ-030 flush sampled high in MISS SHALL be held pending and applied on the cycle after the fill completes. The fill itself SHALL complete normally.
REQ-031 hit_count and miss_count SHALL saturate at 0xFFFFFFFF.

Reset
REQ-032 On resetn=0, SHALL immediately, regardless of clk:
- set state IDLE;
- set proc_ready=0 and mem_req_valid=0;
- set mem_req_addr=0 and proc_rdata=0;
- clear all valid bits, victim pointers, pending flush, hit_count and miss_count.
Tag and data arrays need not be reset.
REQ-033 Reset asserted during MISS SHALL abandon the fill; no array write occurs.

Verification (defaults: 32 sets, index = addr[8:4])
REQ-034 Cold miss then hit:
- fetch 0x10 -> mem_req_valid=1, mem_req_addr=0x10;
- ready with line 0x4444_3333_2222_1111 -> proc_ready pulse, rdata=0x1111, miss_count=1;
- refetch 0x14 -> proc_ready next cycle, rdata=0x2222, no memory request, hit_count=1.
REQ-035 Two-way residency:
- fill 0x010 and 0x210 (set 1);
- fetch both again -> both hit, miss_count=2.
REQ-036 Round-robin eviction:
- fetch 0x410 -> evicts way 0 (0x010);
- then 0x210 hits and 0x010 misses, evicting way 1.
REQ-037 Flush:
- flush pulse in IDLE, then fetch 0x010 -> miss;
- flush during MISS -> the fill completes, then all lines are invalid and the next fetch of the same address misses.
REQ-038 Aborts:
- drop proc_valid during MISS -> no proc_ready; the later fetch hits;
- assert resetn=0 mid-MISS -> mem_req_valid falls without a clock, counters read 0.
